// File: rtl/rs_line_pack_out_if.sv
// Symbol-in / line-out handshake bundle for rs_line_pack_out.
// master = environment side (symbol source and line sink), slave = packer.
interface rs_line_pack_out_if #(
  parameter int DATA_W       = 256,
  parameter int DATA_BYTES_W = $clog2(DATA_W / 8)
);
  logic                    src_packer_byte_val;
  logic [7:0]              src_packer_byte;
  logic                    packer_src_byte_rdy;
  logic                    packer_dst_line_val;
  logic [DATA_W-1:0]       packer_dst_line;
  logic                    packer_dst_line_last;
  logic [DATA_BYTES_W:0]   packer_dst_line_bytes;
  logic                    dst_packer_line_rdy;
  logic                    packer_ctrl_done;

  modport master (
    output src_packer_byte_val, src_packer_byte, dst_packer_line_rdy,
    input  packer_src_byte_rdy, packer_dst_line_val, packer_dst_line,
           packer_dst_line_last, packer_dst_line_bytes, packer_ctrl_done
  );

  modport slave (
    input  src_packer_byte_val, src_packer_byte, dst_packer_line_rdy,
    output packer_src_byte_rdy, packer_dst_line_val, packer_dst_line,
           packer_dst_line_last, packer_dst_line_bytes, packer_ctrl_done
  );
endinterface

// File: rtl/rs_line_pack_out.sv
// Packs RS symbols into DATA_W-bit lines; each block ends in a zero-padded last line.
// Define RS_LINE_PACK_OUT_FIFO_EN to replace the HOLD register with a 2-entry line FIFO.
//
// state | meaning
// FILL  | accepting symbols into the assembly register
// HOLD  | completed line presented, waiting for the sink
module rs_line_pack_out #(
  parameter int DATA_W       = 256,
  parameter int DATA_BYTES   = DATA_W / 8,
  parameter int DATA_BYTES_W = $clog2(DATA_BYTES),
  parameter int BLOCK_BYTES  = 255,
  parameter int BLOCK_CNT_W  = $clog2(BLOCK_BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  rs_line_pack_out_if.slave bus
);

  localparam int RS_WORD_W       = 8;
  localparam int LAST_LINE_BYTES = (BLOCK_BYTES % DATA_BYTES == 0) ? DATA_BYTES
                                                                   : BLOCK_BYTES % DATA_BYTES;

  logic [DATA_BYTES_W-1:0] byte_idx;
  logic [BLOCK_CNT_W-1:0]  blk_idx;
  logic [DATA_W-1:0]       asm_q;
  logic [DATA_W-1:0]       asm_next;
  logic                    byte_xfer;
  logic                    line_xfer;
  logic                    line_end;
  logic                    blk_end;
  logic [DATA_BYTES_W:0]   bytes_next;

  assign byte_xfer  = bus.src_packer_byte_val & bus.packer_src_byte_rdy;
  assign line_xfer  = bus.packer_dst_line_val & bus.dst_packer_line_rdy;
  assign blk_end    = (blk_idx == BLOCK_CNT_W'(BLOCK_BYTES - 1));
  assign line_end   = (byte_idx == DATA_BYTES_W'(DATA_BYTES - 1)) | blk_end;
  assign bytes_next = blk_end ? (DATA_BYTES_W+1)'(LAST_LINE_BYTES)
                              : (DATA_BYTES_W+1)'(DATA_BYTES);

  // Symbol 0 lands in the most significant byte of the line.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (byte_idx == DATA_BYTES_W'(i)) begin
        asm_next[DATA_W-1-RS_WORD_W*i -: RS_WORD_W] = bus.src_packer_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      blk_idx  <= '0;
      asm_q    <= '0;
    end else if (byte_xfer) begin
      if (line_end) begin
        byte_idx <= '0;
        asm_q    <= '0;
      end else begin
        byte_idx <= byte_idx + DATA_BYTES_W'(1);
        asm_q    <= asm_next;
      end
      blk_idx <= blk_end ? '0 : blk_idx + BLOCK_CNT_W'(1);
    end
  end

`ifdef RS_LINE_PACK_OUT_FIFO_EN
  localparam int ENTRY_W = DATA_W + 1 + DATA_BYTES_W + 1;

  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         fifo_cnt;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign push = byte_xfer & line_end;
  assign pop  = line_xfer;
  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {asm_next, blk_end, bytes_next};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bus.packer_src_byte_rdy   = (fifo_cnt != 2'd2);
  assign bus.packer_dst_line_val   = (fifo_cnt != 2'd0);
  assign bus.packer_dst_line       = head[ENTRY_W-1 -: DATA_W];
  assign bus.packer_dst_line_last  = head[DATA_BYTES_W+1];
  assign bus.packer_dst_line_bytes = head[DATA_BYTES_W:0];
  assign bus.packer_ctrl_done      = pop & head[DATA_BYTES_W+1];
`else
  typedef enum logic {FILL, HOLD} state_t;

  state_t                state;
  logic                  byte_rdy;
  logic                  line_val;
  logic                  line_last;
  logic [DATA_W-1:0]     line_q;
  logic [DATA_BYTES_W:0] line_bytes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      byte_rdy   <= 1'b1;
      line_val   <= 1'b0;
      line_last  <= 1'b0;
      line_q     <= '0;
      line_bytes <= '0;
    end else begin
      case (state)
        FILL: begin
          if (byte_xfer && line_end) begin
            line_q     <= asm_next;
            line_last  <= blk_end;
            line_bytes <= bytes_next;
            line_val   <= 1'b1;
            byte_rdy   <= 1'b0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (line_xfer) begin
            line_val <= 1'b0;
            byte_rdy <= 1'b1;
            state    <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.packer_src_byte_rdy   = byte_rdy;
  assign bus.packer_dst_line_val   = line_val;
  assign bus.packer_dst_line       = line_q;
  assign bus.packer_dst_line_last  = line_last;
  assign bus.packer_dst_line_bytes = line_bytes;
  // Done must coincide with the accepting handshake, so it is decoded, not registered.
  assign bus.packer_ctrl_done      = line_xfer & line_last;
`endif

endmodule

// File: tb/tb_rs_line_pack_out.sv
// Scoreboard bench for rs_line_pack_out: a byte-level model queues expected lines,
// a negedge monitor pops and compares them as the DUT hands lines to the sink.
`timescale 1ns/1ps
module tb_rs_line_pack_out;
  localparam int DATA_W = 256;
  localparam int DB     = 32;
  localparam int BB     = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_line_pack_out_if #(.DATA_W(DATA_W)) bus();
  rs_line_pack_out_if #(.DATA_W(DATA_W)) bus64();

  rs_line_pack_out #(.DATA_W(DATA_W), .BLOCK_BYTES(BB)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  rs_line_pack_out #(.DATA_W(DATA_W), .BLOCK_BYTES(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64));

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [5:0]        bytes;
  } line_t;

  line_t             line_q[$];
  int                n_cmp = 0;
  int                n_mis = 0;
  int                blk_pos = 0;
  int                line_pos = 0;
  logic [DATA_W-1:0] cur_line = '0;
  bit                sink_block = 1'b0;
  bit                sink_random = 1'b0;
  int                lines_seen = 0;
  int                dones_seen = 0;
  int                lasts_seen = 0;
  int                sent_cnt = 0;
  int                wait_cycles = 0;
  logic [DATA_W-1:0] last_data = '0;

  function automatic void model_push(input logic [7:0] b);
    line_t l;
    cur_line[DATA_W-1-8*line_pos -: 8] = b;
    sent_cnt++;
    if (line_pos == DB-1 || blk_pos == BB-1) begin
      l.data  = cur_line;
      l.last  = (blk_pos == BB-1);
      l.bytes = 6'(line_pos + 1);
      line_q.push_back(l);
      cur_line = '0;
      line_pos = 0;
    end else begin
      line_pos++;
    end
    blk_pos = (blk_pos == BB-1) ? 0 : blk_pos + 1;
  endfunction

  function automatic void model_reset();
    cur_line = '0;
    line_pos = 0;
    blk_pos  = 0;
    line_q.delete();
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.src_packer_byte_val = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.src_packer_byte_val = 1'b1;
    bus.src_packer_byte     = b;
    t = 0;
    while (bus.packer_src_byte_rdy !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    wait_cycles += t;
    if (t >= 2000) begin
      n_cmp++; n_mis++;
      $display("FAIL byte_rdy_timeout: rdy=%b after %0d cycles, required 1", bus.packer_src_byte_rdy, t);
    end else begin
      model_push(b);
    end
    @(negedge clk);
    bus.src_packer_byte_val = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((line_q.size() != 0 || bus.packer_dst_line_val) && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 500) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d lines still pending, required 0", line_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Sink driver and scoreboard monitor.
  always begin
    line_t e;
    @(negedge clk);
    bus.dst_packer_line_rdy = sink_block ? 1'b0 : (sink_random ? 1'($urandom_range(0, 1)) : 1'b1);
    #1;
    if (bus.packer_dst_line_val === 1'b1 && bus.dst_packer_line_rdy === 1'b1) begin
      lines_seen++;
      last_data = bus.packer_dst_line;
      if (bus.packer_dst_line_last === 1'b1) lasts_seen++;
      n_cmp++;
      if (line_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_line: got line %0h, required none", bus.packer_dst_line);
      end else begin
        e = line_q.pop_front();
        if (bus.packer_dst_line !== e.data) begin
          n_mis++;
          $display("FAIL line_data: got %0h, required %0h", bus.packer_dst_line, e.data);
        end
        n_cmp++;
        if (bus.packer_dst_line_last !== e.last) begin
          n_mis++;
          $display("FAIL line_last: got %b, required %b", bus.packer_dst_line_last, e.last);
        end
        n_cmp++;
        if (bus.packer_dst_line_bytes !== e.bytes) begin
          n_mis++;
          $display("FAIL line_bytes: got %0d, required %0d", bus.packer_dst_line_bytes, e.bytes);
        end
        n_cmp++;
        if (bus.packer_ctrl_done !== e.last) begin
          n_mis++;
          $display("FAIL done_on_xfer: got %b, required %b", bus.packer_ctrl_done, e.last);
        end
      end
    end else if (bus.packer_ctrl_done === 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL spurious_done: got 1 without line transfer, required 0");
    end
    if (bus.packer_ctrl_done === 1'b1) dones_seen++;
  end

  task automatic test_reset();
    #2;
    n_cmp++; if (bus.packer_dst_line_val !== 1'b0) begin n_mis++; $display("FAIL rst_line_val: got %b, required 0", bus.packer_dst_line_val); end
    n_cmp++; if (bus.packer_dst_line !== '0) begin n_mis++; $display("FAIL rst_line: got %0h, required 0", bus.packer_dst_line); end
    n_cmp++; if (bus.packer_dst_line_last !== 1'b0) begin n_mis++; $display("FAIL rst_last: got %b, required 0", bus.packer_dst_line_last); end
    n_cmp++; if (bus.packer_dst_line_bytes !== 6'd0) begin n_mis++; $display("FAIL rst_bytes: got %0d, required 0", bus.packer_dst_line_bytes); end
    n_cmp++; if (bus.packer_ctrl_done !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %b, required 0", bus.packer_ctrl_done); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.packer_src_byte_rdy !== 1'b1) begin n_mis++; $display("FAIL rst_byte_rdy: got %b, required 1", bus.packer_src_byte_rdy); end
  endtask

  task automatic test_one_block();
    int l0 = lines_seen, d0 = dones_seen, w0 = wait_cycles;
`ifdef RS_LINE_PACK_OUT_FIFO_EN
    int exp_waits = 0;
`else
    int exp_waits = 7;
`endif
    for (int i = 0; i < BB; i++) send_byte(8'(i), 0);
    n_cmp++; if (wait_cycles - w0 != exp_waits) begin n_mis++; $display("FAIL block_stall_cycles: got %0d, required %0d", wait_cycles - w0, exp_waits); end
    drain();
    n_cmp++; if (lines_seen - l0 != 8) begin n_mis++; $display("FAIL block_lines: got %0d, required 8", lines_seen - l0); end
    n_cmp++; if (dones_seen - d0 != 1) begin n_mis++; $display("FAIL block_dones: got %0d, required 1", dones_seen - d0); end
    n_cmp++; if (last_data[7:0] !== 8'h00) begin n_mis++; $display("FAIL last_line_pad: got %0h, required 00", last_data[7:0]); end
    n_cmp++; if (last_data[255:248] !== 8'hE0) begin n_mis++; $display("FAIL last_line_head: got %0h, required e0", last_data[255:248]); end
  endtask

  task automatic test_stall();
    int l0 = lines_seen, d0 = dones_seen, s0 = sent_cnt;
`ifdef RS_LINE_PACK_OUT_FIFO_EN
    int exp_sent = 64;
`else
    int exp_sent = 32;
`endif
    sink_block = 1'b1;
    fork
      begin
        for (int i = 0; i < BB; i++) send_byte(8'(i), 0);
      end
      begin
        int t = 0, changed = 0, rdy_hi = 0;
        logic [DATA_W-1:0] held;
        while (bus.packer_dst_line_val !== 1'b1 && t < 300) begin
          @(negedge clk);
          t++;
        end
        n_cmp++; if (t >= 300) begin n_mis++; $display("FAIL stall_val_timeout: got val=%b, required 1", bus.packer_dst_line_val); end
        held = bus.packer_dst_line;
        repeat (40) begin
          @(negedge clk);
          #2;
          if (bus.packer_dst_line !== held) changed++;
          if (bus.packer_src_byte_rdy === 1'b1) rdy_hi++;
        end
        n_cmp++; if (changed != 0) begin n_mis++; $display("FAIL stall_data_stable: got %0d changes, required 0", changed); end
`ifndef RS_LINE_PACK_OUT_FIFO_EN
        n_cmp++; if (rdy_hi != 0) begin n_mis++; $display("FAIL stall_rdy_low: got %0d rdy cycles, required 0", rdy_hi); end
`endif
        n_cmp++; if (sent_cnt - s0 != exp_sent) begin n_mis++; $display("FAIL stall_accepted: got %0d, required %0d", sent_cnt - s0, exp_sent); end
        n_cmp++; if (bus.packer_src_byte_rdy !== 1'b0) begin n_mis++; $display("FAIL stall_rdy_end: got %b, required 0", bus.packer_src_byte_rdy); end
        sink_block = 1'b0;
      end
    join
    drain();
    n_cmp++; if (lines_seen - l0 != 8) begin n_mis++; $display("FAIL stall_lines: got %0d, required 8", lines_seen - l0); end
    n_cmp++; if (dones_seen - d0 != 1) begin n_mis++; $display("FAIL stall_dones: got %0d, required 1", dones_seen - d0); end
  endtask

  task automatic test_back_to_back();
    int l0 = lines_seen, d0 = dones_seen, k0 = lasts_seen;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < BB; i++) send_byte(8'(i), 0);
    drain();
    n_cmp++; if (lines_seen - l0 != 16) begin n_mis++; $display("FAIL b2b_lines: got %0d, required 16", lines_seen - l0); end
    n_cmp++; if (dones_seen - d0 != 2) begin n_mis++; $display("FAIL b2b_dones: got %0d, required 2", dones_seen - d0); end
    n_cmp++; if (lasts_seen - k0 != 2) begin n_mis++; $display("FAIL b2b_lasts: got %0d, required 2", lasts_seen - k0); end
  endtask

  task automatic test_reset_mid();
    int l0, d0;
    for (int i = 0; i < 40; i++) send_byte(8'(i + 8'h80), 0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.packer_dst_line_val !== 1'b0) begin n_mis++; $display("FAIL mid_rst_val: got %b, required 0", bus.packer_dst_line_val); end
    n_cmp++; if (bus.packer_dst_line !== '0) begin n_mis++; $display("FAIL mid_rst_line: got %0h, required 0", bus.packer_dst_line); end
    n_cmp++; if (bus.packer_dst_line_last !== 1'b0) begin n_mis++; $display("FAIL mid_rst_last: got %b, required 0", bus.packer_dst_line_last); end
    n_cmp++; if (bus.packer_dst_line_bytes !== 6'd0) begin n_mis++; $display("FAIL mid_rst_bytes: got %0d, required 0", bus.packer_dst_line_bytes); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.packer_src_byte_rdy !== 1'b1) begin n_mis++; $display("FAIL mid_rst_rdy: got %b, required 1", bus.packer_src_byte_rdy); end
    l0 = lines_seen;
    d0 = dones_seen;
    for (int i = 0; i < BB; i++) send_byte(8'(i), 0);
    drain();
    n_cmp++; if (lines_seen - l0 != 8) begin n_mis++; $display("FAIL mid_rst_lines: got %0d, required 8", lines_seen - l0); end
    n_cmp++; if (dones_seen - d0 != 1) begin n_mis++; $display("FAIL mid_rst_dones: got %0d, required 1", dones_seen - d0); end
  endtask

  task automatic test_random();
    int l0 = lines_seen, d0 = dones_seen;
    sink_random = 1'b1;
    for (int b = 0; b < 10; b++)
      for (int i = 0; i < BB; i++)
        send_byte(8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    drain();
    sink_random = 1'b0;
    n_cmp++; if (dones_seen - d0 != 10) begin n_mis++; $display("FAIL rand_dones: got %0d, required 10", dones_seen - d0); end
    n_cmp++; if (lines_seen - l0 != 80) begin n_mis++; $display("FAIL rand_lines: got %0d, required 80", lines_seen - l0); end
  endtask

  task automatic test_block64();
    int nl = 0;
    bus64.dst_packer_line_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          int t = 0;
          bus64.src_packer_byte_val = 1'b1;
          bus64.src_packer_byte     = 8'(i + 64);
          while (bus64.packer_src_byte_rdy !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
          end
          @(negedge clk);
        end
        bus64.src_packer_byte_val = 1'b0;
      end
      begin
        repeat (200) begin
          @(negedge clk);
          #1;
          if (bus64.packer_dst_line_val === 1'b1) begin
            logic [DATA_W-1:0] exp;
            for (int k = 0; k < DB; k++) exp[DATA_W-1-8*k -: 8] = 8'(nl*32 + k + 64);
            n_cmp++; if (bus64.packer_dst_line !== exp) begin n_mis++; $display("FAIL b64_data: got %0h, required %0h", bus64.packer_dst_line, exp); end
            n_cmp++; if (bus64.packer_dst_line_bytes !== 6'd32) begin n_mis++; $display("FAIL b64_bytes: got %0d, required 32", bus64.packer_dst_line_bytes); end
            n_cmp++; if (bus64.packer_dst_line_last !== 1'(nl == 1)) begin n_mis++; $display("FAIL b64_last: got %b, required %b", bus64.packer_dst_line_last, nl == 1); end
            n_cmp++; if (bus64.packer_ctrl_done !== 1'(nl == 1)) begin n_mis++; $display("FAIL b64_done: got %b, required %b", bus64.packer_ctrl_done, nl == 1); end
            nl++;
          end
        end
      end
    join
    n_cmp++; if (nl != 2) begin n_mis++; $display("FAIL b64_lines: got %0d, required 2", nl); end
  endtask

  initial begin
    bus.src_packer_byte_val     = 1'b0;
    bus.src_packer_byte         = 8'h00;
    bus64.src_packer_byte_val   = 1'b0;
    bus64.src_packer_byte       = 8'h00;
    bus64.dst_packer_line_rdy   = 1'b1;
    test_reset();
    test_one_block();
    test_stall();
    test_back_to_back();
    test_block64();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
